// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding, ALU B-source muxing
// and load-use hazard detection for the 5-stage MIPS core.
module id_ex_operand_stage #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [WIDTH-1:0]  id_rd1,
  input  logic [WIDTH-1:0]  id_rd2,
  input  logic [WIDTH-1:0]  id_sign_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic [3:0]        id_alu_ctrl,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_wreg,
  input  logic [WIDTH-1:0]  exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_wreg,
  input  logic [WIDTH-1:0]  memwb_result,
  output logic [WIDTH-1:0]  read_data_1,
  output logic [WIDTH-1:0]  alu_src_output,
  output logic [3:0]        alu_ctrl,
  output logic [WIDTH-1:0]  ex_store_data,
  output logic [REG_AW-1:0] ex_wreg,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              load_use_hazard
);

  typedef struct packed {
    logic              valid;
    logic [WIDTH-1:0]  rd1;
    logic [WIDTH-1:0]  rd2;
    logic [WIDTH-1:0]  sign_imm;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic              alu_src;
    logic              reg_dst;
    logic [3:0]        alu_ctrl;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
  } ex_fields_t;

  ex_fields_t ex_d, ex_q;

  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = '0;
    end else if (!stall) begin
      ex_d.valid      = id_valid;
      ex_d.rd1        = id_rd1;
      ex_d.rd2        = id_rd2;
      ex_d.sign_imm   = id_sign_imm;
      ex_d.rs         = id_rs;
      ex_d.rt         = id_rt;
      ex_d.rd         = id_rd;
      ex_d.alu_src    = id_alu_src;
      ex_d.reg_dst    = id_reg_dst;
      ex_d.alu_ctrl   = id_alu_ctrl;
      ex_d.reg_write  = id_reg_write;
      ex_d.mem_read   = id_mem_read;
      ex_d.mem_write  = id_mem_write;
      ex_d.mem_to_reg = id_mem_to_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  logic             exmem_hit_a, memwb_hit_a, exmem_hit_b, memwb_hit_b;
  logic [WIDTH-1:0] fwd_b;

  // $0 never forwards; EX/MEM is the younger producer so it wins over MEM/WB.
  always_comb begin
    exmem_hit_a = exmem_reg_write && (exmem_wreg != '0) && (exmem_wreg == ex_q.rs);
    memwb_hit_a = memwb_reg_write && (memwb_wreg != '0) && (memwb_wreg == ex_q.rs);
    exmem_hit_b = exmem_reg_write && (exmem_wreg != '0) && (exmem_wreg == ex_q.rt);
    memwb_hit_b = memwb_reg_write && (memwb_wreg != '0) && (memwb_wreg == ex_q.rt);

    if (exmem_hit_a)      read_data_1 = exmem_result;
    else if (memwb_hit_a) read_data_1 = memwb_result;
    else                  read_data_1 = ex_q.rd1;

    if (exmem_hit_b)      fwd_b = exmem_result;
    else if (memwb_hit_b) fwd_b = memwb_result;
    else                  fwd_b = ex_q.rd2;
  end

  assign alu_src_output = ex_q.alu_src ? ex_q.sign_imm : fwd_b;
  assign ex_store_data  = fwd_b;
  assign alu_ctrl       = ex_q.alu_ctrl;
  assign ex_wreg        = ex_q.reg_dst ? ex_q.rd : ex_q.rt;

  // Controls are qualified by valid so an invalid slot can never write state.
  assign ex_valid      = ex_q.valid;
  assign ex_reg_write  = ex_q.valid & ex_q.reg_write;
  assign ex_mem_read   = ex_q.valid & ex_q.mem_read;
  assign ex_mem_write  = ex_q.valid & ex_q.mem_write;
  assign ex_mem_to_reg = ex_q.valid & ex_q.mem_to_reg;

  assign load_use_hazard = ex_mem_read && (ex_wreg != '0) &&
                           ((ex_wreg == id_rs) || (ex_wreg == id_rt));

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed vector table, hand sequences for
// reset/load-use/flush corner cases, and randomized traffic against a behavioural model.
module tb_id_ex_operand_stage;

  typedef struct {
    logic        valid;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
    logic        alu_src, reg_dst;
    logic [3:0]  ctrl;
    logic        rw, mr, mw, m2r;
  } instr_t;

  typedef struct {
    instr_t      in;
    logic        exw;
    logic [4:0]  exwreg;
    logic [31:0] exres;
    logic        mww;
    logic [4:0]  mwreg;
    logic [31:0] mwres;
    logic [31:0] exp_a, exp_b, exp_sd;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall = 1'b0;
  logic flush = 1'b0;
  instr_t drv;
  logic        exmem_reg_write = 1'b0;
  logic [4:0]  exmem_wreg = '0;
  logic [31:0] exmem_result = '0;
  logic        memwb_reg_write = 1'b0;
  logic [4:0]  memwb_wreg = '0;
  logic [31:0] memwb_result = '0;

  logic [31:0] read_data_1, alu_src_output, ex_store_data;
  logic [3:0]  alu_ctrl;
  logic [4:0]  ex_wreg;
  logic ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, load_use_hazard;

  int tests = 0;
  int fails = 0;
  instr_t m;  // model of the instruction currently held in EX

  always #5 clk = ~clk;

  id_ex_operand_stage #(.WIDTH(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .id_valid(drv.valid), .id_rd1(drv.rd1), .id_rd2(drv.rd2), .id_sign_imm(drv.imm),
    .id_rs(drv.rs), .id_rt(drv.rt), .id_rd(drv.rd),
    .id_alu_src(drv.alu_src), .id_reg_dst(drv.reg_dst), .id_alu_ctrl(drv.ctrl),
    .id_reg_write(drv.rw), .id_mem_read(drv.mr), .id_mem_write(drv.mw),
    .id_mem_to_reg(drv.m2r),
    .exmem_reg_write(exmem_reg_write), .exmem_wreg(exmem_wreg), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_wreg(memwb_wreg), .memwb_result(memwb_result),
    .read_data_1(read_data_1), .alu_src_output(alu_src_output), .alu_ctrl(alu_ctrl),
    .ex_store_data(ex_store_data), .ex_wreg(ex_wreg), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .load_use_hazard(load_use_hazard)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] regval);
    if (src == 0) return regval;
    if (exmem_reg_write && exmem_wreg == src) return exmem_result;
    if (memwb_reg_write && memwb_wreg == src) return memwb_result;
    return regval;
  endfunction

  function automatic instr_t rand_instr();
    instr_t x;
    x.valid = 1'($urandom_range(0, 3) != 0);
    x.rd1 = $urandom; x.rd2 = $urandom; x.imm = $urandom;
    x.rs = 5'($urandom_range(0, 4)); x.rt = 5'($urandom_range(0, 4));
    x.rd = 5'($urandom_range(0, 4));
    x.alu_src = 1'($urandom); x.reg_dst = 1'($urandom);
    x.ctrl = 4'($urandom);
    x.rw = 1'($urandom); x.mr = 1'($urandom); x.mw = 1'($urandom); x.m2r = 1'($urandom);
    return x;
  endfunction

  // Compare every output against the model's view of the EX instruction.
  task automatic check_all(input string tag);
    logic [4:0] w;
    logic [31:0] b;
    logic haz;
    w = m.reg_dst ? m.rd : m.rt;
    b = fwd(m.rt, m.rd2);
    haz = m.valid && m.mr && w != 0 && (w == drv.rs || w == drv.rt);
    chk({tag, ".ex_valid"}, 32'(ex_valid), 32'(m.valid));
    chk({tag, ".reg_write"}, 32'(ex_reg_write), 32'(m.valid & m.rw));
    chk({tag, ".mem_read"}, 32'(ex_mem_read), 32'(m.valid & m.mr));
    chk({tag, ".mem_write"}, 32'(ex_mem_write), 32'(m.valid & m.mw));
    chk({tag, ".mem_to_reg"}, 32'(ex_mem_to_reg), 32'(m.valid & m.m2r));
    chk({tag, ".alu_ctrl"}, 32'(alu_ctrl), 32'(m.ctrl));
    chk({tag, ".ex_wreg"}, 32'(ex_wreg), 32'(w));
    chk({tag, ".read_data_1"}, read_data_1, fwd(m.rs, m.rd1));
    chk({tag, ".alu_src_output"}, alu_src_output, m.alu_src ? m.imm : b);
    chk({tag, ".store_data"}, ex_store_data, b);
    chk({tag, ".load_use"}, 32'(load_use_hazard), 32'(haz));
  endtask

  // One rising edge; the model takes the same flush > stall > capture decision.
  task automatic tick();
    @(posedge clk);
    if (flush) m = '{default: '0};
    else if (!stall) m = drv;
    #1;
  endtask

  task automatic clear_fwd();
    exmem_reg_write = 0; exmem_wreg = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_wreg = 0; memwb_result = 0;
  endtask

  vec_t vecs[7];

  initial begin
    instr_t b0;
    b0 = '{default: '0};
    m = b0;
    drv = b0;
    b0.valid = 1; b0.rd1 = 32'd11; b0.rd2 = 32'd22; b0.imm = 32'h1234; b0.ctrl = 4'b0010;

    vecs[0] = '{b0, 0, 0, 0, 0, 0, 0, 32'd50, 32'd20, 32'd20};
    vecs[0].in.rd1 = 32'd50; vecs[0].in.rd2 = 32'd20;
    vecs[1] = '{b0, 0, 0, 0, 0, 0, 0, 32'd11, 32'hFFFF_FFFC, 32'd33};
    vecs[1].in.alu_src = 1; vecs[1].in.imm = 32'hFFFF_FFFC; vecs[1].in.rd2 = 32'd33;
    vecs[2] = '{b0, 1, 5, 7, 1, 5, 9, 32'd7, 32'd7, 32'd7};
    vecs[2].in.rs = 5; vecs[2].in.rt = 5;
    vecs[3] = '{b0, 0, 5, 7, 1, 5, 9, 32'd9, 32'd9, 32'd9};
    vecs[3].in.rs = 5; vecs[3].in.rt = 5;
    vecs[4] = '{b0, 1, 0, 7, 1, 0, 9, 32'd11, 32'd22, 32'd22};
    vecs[5] = '{b0, 1, 4, 100, 1, 3, 200, 32'd200, 32'd100, 32'd100};
    vecs[5].in.rs = 3; vecs[5].in.rt = 4;
    vecs[6] = '{b0, 0, 0, 0, 1, 6, 77, 32'd11, 32'h1234, 32'd77};
    vecs[6].in.alu_src = 1; vecs[6].in.rt = 6;

    // Reset state
    #12;
    check_all("reset");
    rst_n = 1;
    tick();

    foreach (vecs[i]) begin
      drv = vecs[i].in;
      clear_fwd();
      tick();
      exmem_reg_write = vecs[i].exw; exmem_wreg = vecs[i].exwreg;
      exmem_result = vecs[i].exres;
      memwb_reg_write = vecs[i].mww; memwb_wreg = vecs[i].mwreg;
      memwb_result = vecs[i].mwres;
      #1;
      chk($sformatf("vec%0d.A", i), read_data_1, vecs[i].exp_a);
      chk($sformatf("vec%0d.B", i), alu_src_output, vecs[i].exp_b);
      chk($sformatf("vec%0d.store", i), ex_store_data, vecs[i].exp_sd);
    end
    clear_fwd();

    // Load-use: lw to $8 in EX, dependent instruction held in ID across a stall
    drv = b0; drv.mr = 1; drv.rw = 1; drv.m2r = 1; drv.rt = 8; drv.rs = 1;
    tick();
    drv = b0; drv.rs = 8; drv.rt = 2; drv.rd1 = 32'hAA;
    #1;
    chk("lu.hazard", 32'(load_use_hazard), 32'd1);
    stall = 1;
    tick();
    chk("lu.hold_wreg", 32'(ex_wreg), 32'd8);
    chk("lu.hold_mr", 32'(ex_mem_read), 32'd1);
    chk("lu.hold_hazard", 32'(load_use_hazard), 32'd1);
    stall = 0;
    tick();
    chk("lu.released_a", read_data_1, 32'hAA);
    chk("lu.released_hazard", 32'(load_use_hazard), 32'd0);
    check_all("lu");

    // Flush and stall together with a real instruction in ID
    drv = b0; drv.rw = 1; drv.ctrl = 4'b0111;
    flush = 1; stall = 1;
    tick();
    chk("fs.valid", 32'(ex_valid), 32'd0);
    chk("fs.reg_write", 32'(ex_reg_write), 32'd0);
    chk("fs.alu_ctrl", 32'(alu_ctrl), 32'd0);
    flush = 0; stall = 0;

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      drv = rand_instr();
      stall = 1'($urandom_range(0, 3) == 0);
      flush = 1'($urandom_range(0, 7) == 0);
      tick();
      exmem_reg_write = 1'($urandom); exmem_wreg = 5'($urandom_range(0, 4));
      exmem_result = $urandom;
      memwb_reg_write = 1'($urandom); memwb_wreg = 5'($urandom_range(0, 4));
      memwb_result = $urandom;
      drv = rand_instr();
      #1;
      check_all($sformatf("rnd%0d", n));
    end

    // Asynchronous reset mid-cycle while stalled
    drv = b0; stall = 0; flush = 0; clear_fwd();
    tick();
    stall = 1;
    #2;
    rst_n = 0;
    m = '{default: '0};
    #1;
    check_all("async_rst");
    chk("async_rst.A", read_data_1, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
